// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, DONE} state_t;

  typedef enum logic {REQ_CPU = 1'b0, REQ_LDR = 1'b1} req_id_t;

  localparam int WAIT_STATES_DEFAULT = 2;

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester arbiter driving an asynchronous SRAM with active-low strobes.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise the loader has fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [19:0] i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  output logic [15:0] o_cpu_rdata,
  output logic        o_cpu_ready,
  input  logic        i_ldr_req,
  input  logic        i_ldr_we,
  input  logic [19:0] i_ldr_addr,
  input  logic [15:0] i_ldr_wdata,
  output logic [15:0] o_ldr_rdata,
  output logic        o_ldr_ready,
  output logic [19:0] o_a,
  input  logic [15:0] i_data_in,
  output logic [15:0] o_data_out,
  output logic        o_data_oe,
  output logic        o_ce,
  output logic        o_ub,
  output logic        o_lb,
  output logic        o_oe,
  output logic        o_we
);

  localparam logic [3:0] LP_COUNT_LOAD = 4'(WAIT_STATES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_count;
  req_id_t     r_winner;
  logic [19:0] r_addr;
  logic        r_we;
  logic [15:0] r_wdata;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_ldr_rdata;
  logic        w_any_req;
  logic        w_grant_ldr;

  assign w_any_req = i_cpu_req | i_ldr_req;

`ifdef SRAM_ARB_RR_EN
  // Pointer remembers the last grant so a collision goes to the other side.
  req_id_t r_last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= REQ_CPU;
    end else if (r_state == IDLE && w_any_req) begin
      r_last <= w_grant_ldr ? REQ_LDR : REQ_CPU;
    end
  end

  assign w_grant_ldr = i_ldr_req & (~i_cpu_req | (r_last == REQ_CPU));
`else
  assign w_grant_ldr = i_ldr_req;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = SETUP;
      SETUP:   w_next = ACTIVE;
      ACTIVE:  if (r_count == 4'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request inputs are only looked at in IDLE; the transfer runs on latched copies.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count     <= 4'd0;
      r_winner    <= REQ_CPU;
      r_addr      <= 20'd0;
      r_we        <= 1'b0;
      r_wdata     <= 16'd0;
      r_cpu_rdata <= 16'd0;
      r_ldr_rdata <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_winner <= w_grant_ldr ? REQ_LDR : REQ_CPU;
            r_addr   <= w_grant_ldr ? i_ldr_addr  : i_cpu_addr;
            r_we     <= w_grant_ldr ? i_ldr_we    : i_cpu_we;
            r_wdata  <= w_grant_ldr ? i_ldr_wdata : i_cpu_wdata;
          end
        end
        SETUP: r_count <= LP_COUNT_LOAD;
        ACTIVE: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else if (!r_we) begin
            // Sample while OE is still low so the data is valid alongside ready.
            if (r_winner == REQ_LDR) r_ldr_rdata <= i_data_in;
            else                     r_cpu_rdata <= i_data_in;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ce        = 1'b1;
    o_ub        = 1'b1;
    o_lb        = 1'b1;
    o_oe        = 1'b1;
    o_we        = 1'b1;
    o_data_oe   = 1'b0;
    o_cpu_ready = 1'b0;
    o_ldr_ready = 1'b0;
    case (r_state)
      SETUP: begin
        o_ce      = 1'b0;
        o_ub      = 1'b0;
        o_lb      = 1'b0;
        o_oe      = r_we;
        o_data_oe = r_we;
      end
      ACTIVE: begin
        o_ce      = 1'b0;
        o_ub      = 1'b0;
        o_lb      = 1'b0;
        o_oe      = r_we;
        o_we      = ~r_we;
        o_data_oe = r_we;
      end
      DONE: begin
        o_ce        = 1'b0;
        o_ub        = 1'b0;
        o_lb        = 1'b0;
        o_data_oe   = r_we;
        o_cpu_ready = (r_winner == REQ_CPU);
        o_ldr_ready = (r_winner == REQ_LDR);
      end
      default: ;
    endcase
  end

  assign o_a         = r_addr;
  assign o_data_out  = r_wdata;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_ldr_rdata = r_ldr_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, phase-based reference model and directed transfers.
module tb_sram_arbiter;

  localparam int WS = 2;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuReq, cpuWe, ldrReq, ldrWe;
  logic [19:0] cpuAddr, ldrAddr, a;
  logic [15:0] cpuWdata, ldrWdata, cpuRdata, ldrRdata;
  logic        cpuReady, ldrReady;
  logic [15:0] dataIn, dataOut;
  logic        dataOe, ce, ub, lb, oe, we;

  logic        preloadEn;
  logic [11:0] preloadAddr;
  logic [15:0] preloadData;
  logic [15:0] sram [0:4095];
  logic [15:0] gold [0:4095];

  logic        mBusy, mWe, mWin, mLastLdr;
  int          mPhase;
  logic [19:0] mAddr;
  logic [15:0] mWdata, mCpuRd, mLdrRd;

  logic        checkEn;
  int          nCompared, nMismatched;
  int          oeLowCnt, weLowCnt, doeCnt, cpuPulses, ldrPulses;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_STATES(WS)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cpu_req(cpuReq), .i_cpu_we(cpuWe), .i_cpu_addr(cpuAddr), .i_cpu_wdata(cpuWdata),
    .o_cpu_rdata(cpuRdata), .o_cpu_ready(cpuReady),
    .i_ldr_req(ldrReq), .i_ldr_we(ldrWe), .i_ldr_addr(ldrAddr), .i_ldr_wdata(ldrWdata),
    .o_ldr_rdata(ldrRdata), .o_ldr_ready(ldrReady),
    .o_a(a), .i_data_in(dataIn), .o_data_out(dataOut), .o_data_oe(dataOe),
    .o_ce(ce), .o_ub(ub), .o_lb(lb), .o_oe(oe), .o_we(we)
  );

  // Asynchronous SRAM: drives data only while selected and output-enabled.
  assign dataIn = (!ce && !oe) ? sram[a[11:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (preloadEn) sram[preloadAddr] <= preloadData;
    else if (!ce && !we) sram[a[11:0]] <= dataOe ? dataOut : 16'hBAD0;
  end

  function automatic logic pickLdr(input logic c, input logic l, input logic lastLdr);
    return l && (!c || !RR || !lastLdr);
  endfunction

  // Reference: a transfer is phase 1 (setup), 2..WS+1 (strobe), WS+2 (complete).
  always @(posedge clk) begin
    if (preloadEn) gold[preloadAddr] <= preloadData;
    if (reset) begin
      mBusy    <= 1'b0;
      mPhase   <= 0;
      mLastLdr <= 1'b0;
      mCpuRd   <= 16'd0;
      mLdrRd   <= 16'd0;
    end else if (!mBusy) begin
      if (cpuReq || ldrReq) begin
        mBusy    <= 1'b1;
        mPhase   <= 1;
        mWin     <= pickLdr(cpuReq, ldrReq, mLastLdr);
        mLastLdr <= pickLdr(cpuReq, ldrReq, mLastLdr);
        mAddr    <= pickLdr(cpuReq, ldrReq, mLastLdr) ? ldrAddr : cpuAddr;
        mWe      <= pickLdr(cpuReq, ldrReq, mLastLdr) ? ldrWe : cpuWe;
        mWdata   <= pickLdr(cpuReq, ldrReq, mLastLdr) ? ldrWdata : cpuWdata;
      end
    end else if (mPhase == WS + 2) begin
      mBusy  <= 1'b0;
      mPhase <= 0;
      if (mWe) gold[mAddr[11:0]] <= mWdata;
    end else begin
      mPhase <= mPhase + 1;
      if (mPhase == WS + 1 && !mWe) begin
        if (mWin) mLdrRd <= gold[mAddr[11:0]];
        else      mCpuRd <= gold[mAddr[11:0]];
      end
    end
  end

  // Bit order: ce, ub, lb, oe, we, data_oe, cpu_ready, ldr_ready.
  function automatic logic [7:0] expStrobes();
    logic [7:0] v;
    v = 8'b11111000;
    if (mBusy) begin
      if (mPhase <= WS + 1) v = {3'b000, mWe, (mPhase >= 2) ? !mWe : 1'b1, mWe, 2'b00};
      else                  v = {3'b000, 1'b1, 1'b1, mWe, !mWin, mWin};
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (!oe) oeLowCnt++;
      if (!we) weLowCnt++;
      if (dataOe) doeCnt++;
      if (cpuReady) cpuPulses++;
      if (ldrReady) ldrPulses++;
      if (checkEn) begin
        checkOutput("strobes", {24'd0, ce, ub, lb, oe, we, dataOe, cpuReady, ldrReady}, {24'd0, expStrobes()});
        if (mBusy) checkOutput("addr", {12'd0, a}, {12'd0, mAddr});
        if (mBusy && mWe) checkOutput("wdata", {16'd0, dataOut}, {16'd0, mWdata});
        checkOutput("cpu_rdata", {16'd0, cpuRdata}, {16'd0, mCpuRd});
        checkOutput("ldr_rdata", {16'd0, ldrRdata}, {16'd0, mLdrRd});
      end
    end
  endtask

  task automatic preload(input logic [11:0] addr, input logic [15:0] data);
    @(negedge clk);
    preloadEn   = 1'b1;
    preloadAddr = addr;
    preloadData = data;
    @(negedge clk);
    preloadEn = 1'b0;
  endtask

  // Requester holds req until it sees ready; lat counts the request cycle as 1.
  task automatic applyStimulus(input logic isLdr, input logic w, input logic [19:0] addr,
                               input logic [15:0] wd, output int lat, output logic [15:0] rd);
    @(negedge clk);
    if (isLdr) begin
      ldrReq = 1'b1; ldrWe = w; ldrAddr = addr; ldrWdata = wd;
    end else begin
      cpuReq = 1'b1; cpuWe = w; cpuAddr = addr; cpuWdata = wd;
    end
    lat = 0;
    rd  = 16'd0;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (isLdr ? ldrReady : cpuReady) begin
        lat = n;
        rd  = isLdr ? ldrRdata : cpuRdata;
        break;
      end
    end
    if (isLdr) ldrReq = 1'b0;
    else       cpuReq = 1'b0;
    if (lat == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL ready_timeout actual=none required=pulse requester=%0d", isLdr);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          latA, latB, p0;
    logic [15:0] rdA, rdB, v;
    reset = 1'b1;
    cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuWdata = 0;
    ldrReq = 0; ldrWe = 0; ldrAddr = 0; ldrWdata = 0;
    preloadEn = 0; preloadAddr = 0; preloadData = 0;
    checkEn = 0; nCompared = 0; nMismatched = 0;
    oeLowCnt = 0; weLowCnt = 0; doeCnt = 0; cpuPulses = 0; ldrPulses = 0;
    fork
      compareLoop();
    join_none

    preload(12'h05A, 16'h1234);
    preload(12'h200, 16'hBEEF);
    preload(12'hFFF, 16'h5555);
    preload(12'h300, 16'h1111);
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_strobes", {24'd0, ce, ub, lb, oe, we, dataOe, cpuReady, ldrReady}, 32'h000000F8);
    checkOutput("rst_addr", {12'd0, a}, 32'd0);
    checkOutput("rst_rdata", {cpuRdata, ldrRdata}, 32'd0);
    reset = 1'b0;

    // Single CPU read.
    oeLowCnt = 0;
    applyStimulus(1'b0, 1'b0, 20'h0005A, 16'h0, latA, rdA);
    @(negedge clk);
    checkOutput("rd_latency", latA, 32'd5);
    checkOutput("rd_data", {16'd0, rdA}, 32'h1234);
    checkOutput("rd_oe_low_cycles", oeLowCnt, 32'd3);

    // Loader write, then read back through the CPU port.
    weLowCnt = 0; doeCnt = 0;
    applyStimulus(1'b1, 1'b1, 20'h00100, 16'h0606, latA, rdA);
    @(negedge clk);
    checkOutput("wr_latency", latA, 32'd5);
    checkOutput("wr_we_low_cycles", weLowCnt, 32'd2);
    checkOutput("wr_data_oe_cycles", doeCnt, 32'd4);
    applyStimulus(1'b0, 1'b0, 20'h00100, 16'h0, latA, rdA);
    checkOutput("wr_readback", {16'd0, rdA}, 32'h0606);

    // Collision after a CPU grant: loader first either way.
    fork
      applyStimulus(1'b1, 1'b0, 20'h0005A, 16'h0, latA, rdA);
      applyStimulus(1'b0, 1'b0, 20'h00200, 16'h0, latB, rdB);
    join
    checkOutput("col1_ldr_latency", latA, 32'd5);
    checkOutput("col1_cpu_latency", latB, 32'd10);
    checkOutput("col1_ldr_data", {16'd0, rdA}, 32'h1234);
    checkOutput("col1_cpu_data", {16'd0, rdB}, 32'hBEEF);

    // Collision after a loader grant: round-robin hands it to the CPU.
    applyStimulus(1'b1, 1'b1, 20'h00400, 16'h4444, latA, rdA);
    fork
      applyStimulus(1'b1, 1'b0, 20'h0005A, 16'h0, latA, rdA);
      applyStimulus(1'b0, 1'b0, 20'h00400, 16'h0, latB, rdB);
    join
    checkOutput("col2_ldr_latency", latA, RR ? 32'd10 : 32'd5);
    checkOutput("col2_cpu_latency", latB, RR ? 32'd5 : 32'd10);
    checkOutput("col2_cpu_data", {16'd0, rdB}, 32'h4444);

    // CPU drops its request and changes address after setup.
    @(negedge clk);
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 20'h00200;
    @(negedge clk);
    cpuReq = 1'b0; cpuAddr = 20'h00FFF;
    p0 = cpuPulses;
    rdA = 16'd0;
    repeat (12) begin
      @(negedge clk);
      if (cpuReady) rdA = cpuRdata;
    end
    checkOutput("drop_ready_pulses", cpuPulses - p0, 32'd1);
    checkOutput("drop_data", {16'd0, rdA}, 32'hBEEF);

    // Reset during the strobe phase of a loader write.
    @(negedge clk);
    ldrReq = 1'b1; ldrWe = 1'b1; ldrAddr = 20'h00300; ldrWdata = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; ldrReq = 1'b0;
    p0 = ldrPulses;
    @(negedge clk);
    checkOutput("mid_rst_strobes", {24'd0, ce, ub, lb, oe, we, dataOe, cpuReady, ldrReady}, 32'h000000F8);
    checkOutput("mid_rst_addr", {12'd0, a}, 32'd0);
    checkOutput("mid_rst_rdata", {cpuRdata, ldrRdata}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("mid_rst_no_ready", ldrPulses - p0, 32'd0);
    v = sram[12'h300];
    checkOutput("mid_rst_mem_whole", {31'd0, (v == 16'h1111) || (v == 16'hAAAA)}, 32'd1);

    // CPU write then loader read; CPU rdata must hold.
    applyStimulus(1'b0, 1'b1, 20'h00500, 16'hC0DE, latA, rdA);
    applyStimulus(1'b1, 1'b0, 20'h00500, 16'h0, latA, rdA);
    checkOutput("ldr_readback", {16'd0, rdA}, 32'hC0DE);
    checkOutput("ldr_readback_latency", latA, 32'd5);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
